fibo_request_sequencer: RTL and testbench

Host-side driver for the team's Fibonacci calculator; it owns the calculator side of the `input_s` / `begin_fibo` / `fibo_out` / `done` handshake. On one command it issues a run of consecutive indices and resets the calculator between requests. It captures each result into an output FIFO and cross-checks consecutive results against F(n)=F(n-1)+F(n-2). It sits between a host or bench controller and one calculator instance.

---
 rtl/fibo_pkg.sv | 41 ++++
 rtl/fibo_result_fifo.sv | 52 +++++
 rtl/fibo_request_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fibo_request_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci request sequencer.
package fibo_pkg;

    localparam int IDX_W        = 5;
    localparam int DATA_W       = 16;
    localparam int MAX_FIBO_IDX = 24;

    localparam int CRST_CYC   = 2;
    localparam int SETTLE_CYC = 2;
    localparam int BEGIN_CYC  = 2;
    localparam int ABORT_CYC  = 2;

    // Wide enough to count the longest fixed-length phase.
    localparam int PHASE_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_SETTLE,
        S_BEGIN,
        S_WAIT,
        S_CAPTURE,
        S_ABORT
    } state_t;

    // A run is legal when it has at least one request and its last index
    // still fits a 16-bit result.
    function automatic logic cmd_ok(input logic [IDX_W-1:0] first,
                                    input logic [IDX_W-1:0] cnt);
        logic [IDX_W:0] last_plus1;
        last_plus1 = {1'b0, first} + {1'b0, cnt};
        return (cnt != '0) && (int'(last_plus1) <= MAX_FIBO_IDX + 1);
    endfunction

    // True on the final cycle of a phase lasting cyc cycles.
    function automatic logic phase_last(input logic [PHASE_W-1:0] phase,
                                        input int                 cyc);
        return int'(phase) == cyc - 1;
    endfunction

endpackage

// File: rtl/fibo_result_fifo.sv
// First-word fall-through result FIFO; full/empty derived from occupancy.
module fibo_result_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             do_push;
    logic             do_pop;

    assign full      = (occ == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (occ == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage array carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fibo_request_sequencer.sv
// Drives one Fibonacci calculator through a run of consecutive indices,
// queues each result with its index, and cross-checks the recurrence.
module fibo_request_sequencer
    import fibo_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_s,
    input  logic [IDX_W-1:0]  count,
    output logic              busy,
    output logic              cmd_err,
    output logic              chk_err,
    output logic              timeout_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_index,
    output logic              calc_reset_n,
    output logic [IDX_W-1:0]  input_s,
    output logic              begin_fibo,
    input  logic [DATA_W-1:0] fibo_out,
    input  logic              done
);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int ENTRY_W = IDX_W + DATA_W;

    state_t             state;
    state_t             state_d;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_d;
    logic [TO_W-1:0]    tcnt;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   remaining;
    logic [1:0]         hist_cnt;
    logic [DATA_W-1:0]  prev1;
    logic [DATA_W-1:0]  prev2;
    logic               accept;
    logic               reject;
    logic               push;
    logic               to_hit;
    logic               last_req;
    logic               chk_bad;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    // Expected value of the next term; legal indices never overflow 16 bits.
    function automatic logic [DATA_W-1:0] recur_sum(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign last_req = (remaining == IDX_W'(1));
    assign chk_bad  = (hist_cnt == 2'd2) && (fibo_out != recur_sum(prev1, prev2));

    // Next-state and strobe decode; the phase counter restarts on every state change.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        reject  = 1'b0;
        push    = 1'b0;
        to_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cmd_ok(first_s, count)) begin
                        accept  = 1'b1;
                        state_d = S_CRST;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_CRST:   if (phase_last(phase, CRST_CYC))   state_d = S_SETTLE;
            S_SETTLE: if (phase_last(phase, SETTLE_CYC)) state_d = S_BEGIN;
            S_BEGIN:  if (phase_last(phase, BEGIN_CYC))  state_d = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    state_d = S_CAPTURE;
                end else if (int'(tcnt) == TIMEOUT_CYC - 1) begin
                    to_hit  = 1'b1;
                    state_d = S_ABORT;
                end
            end
            S_CAPTURE: begin
                // Full is judged on occupancy alone, so a same-cycle pop
                // only frees the slot for the following cycle.
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = last_req ? S_IDLE : S_CRST;
                end
            end
            S_ABORT:  if (phase_last(phase, ABORT_CYC)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        phase_d = (state_d != state) ? '0 : phase + PHASE_W'(1);
    end

    // State, phase and WAIT timeout registers; the timeout count is zero on WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            phase <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_d;
            phase <= phase_d;
            tcnt  <= (state == S_WAIT) ? tcnt + TO_W'(1) : '0;
        end
    end

    // Registered calculator-facing and status outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            cmd_err      <= 1'b0;
            calc_reset_n <= 1'b0;
            begin_fibo   <= 1'b0;
            input_s      <= '0;
        end else begin
            busy         <= (state_d != S_IDLE);
            cmd_err      <= reject;
            calc_reset_n <= !((state_d == S_CRST) || (state_d == S_ABORT));
            begin_fibo   <= (state_d == S_BEGIN);
            if (state_d == S_BEGIN) input_s <= cur_idx;
        end
    end

    // Run bookkeeping: index/remaining count, checker history depth, sticky errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_idx     <= '0;
            remaining   <= '0;
            hist_cnt    <= '0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                cur_idx     <= first_s;
                remaining   <= count;
                hist_cnt    <= '0;
                chk_err     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (to_hit) timeout_err <= 1'b1;
            if (push) begin
                if (chk_bad) chk_err <= 1'b1;
                if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
                if (!last_req) begin
                    cur_idx   <= cur_idx + IDX_W'(1);
                    remaining <= remaining - IDX_W'(1);
                end
            end
        end
    end

    // Checker history values; validity is tracked by hist_cnt, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            prev2 <= prev1;
            prev1 <= fibo_out;
        end
    end

    fibo_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push),
        .push_data ({cur_idx, fibo_out}),
        .pop       (res_ready),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_index = head[ENTRY_W-1:DATA_W];
    assign res_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_fibo_request_sequencer.sv
// Self-checking bench: behavioural calculator, table-driven runs, and
// hand-written sequences for stall, checker, timeout and mid-run reset.
module tb_fibo_request_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [4:0]  first_s;
    logic [4:0]  count;
    logic        busy;
    logic        cmd_err;
    logic        chk_err;
    logic        timeout_err;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [4:0]  res_index;
    logic        calc_reset_n;
    logic [4:0]  input_s;
    logic        begin_fibo;
    logic [15:0] fibo_out;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fibo_request_sequencer #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .first_s      (first_s),
        .count        (count),
        .busy         (busy),
        .cmd_err      (cmd_err),
        .chk_err      (chk_err),
        .timeout_err  (timeout_err),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_index    (res_index),
        .calc_reset_n (calc_reset_n),
        .input_s      (input_s),
        .begin_fibo   (begin_fibo),
        .fibo_out     (fibo_out),
        .done         (done)
    );

    // ---------------- behavioural calculator ----------------
    logic        never_done = 1'b0;
    logic        bad3       = 1'b0;
    logic        m_done     = 1'b0;
    logic        m_run      = 1'b0;
    logic [15:0] m_out      = 16'd0;
    logic [4:0]  m_idx      = 5'd0;
    int          m_cnt      = 0;

    function automatic logic [15:0] fib(input logic [4:0] n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        if (!calc_reset_n) begin
            m_done <= 1'b0;
            m_run  <= 1'b0;
        end else if (m_run) begin
            if (m_cnt == 2) begin
                m_run  <= 1'b0;
                m_done <= !never_done;
                m_out  <= (bad3 && m_idx == 5'd3) ? 16'd7 : fib(m_idx);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (begin_fibo && !m_done) begin
            m_run <= 1'b1;
            m_idx <= input_s;
            m_cnt <= 0;
        end
    end

    assign done     = m_done;
    assign fibo_out = m_out;

    // ---------------- output monitor (negedge) ----------------
    logic [20:0] got_q[$];
    int          begin_cnt  = 0;
    int          rstlow_cnt = 0;

    always @(negedge clk) begin
        if (res_valid && res_ready) got_q.push_back({res_index, res_data});
        if (begin_fibo) begin_cnt <= begin_cnt + 1;
        if (reset_n && !calc_reset_n) rstlow_cnt <= rstlow_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [4:0] f, input logic [4:0] c);
        first_s = f;
        count   = c;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (!busy) break;
            tick(1);
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic wait_sig(input string name, input logic want, input int which);
        int i;
        logic v;
        for (i = 0; i < 1000; i++) begin
            v = (which == 0) ? begin_fibo : res_valid;
            if (v == want) break;
            tick(1);
        end
        check(name, v, want);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]        first;
        logic [4:0]        cnt;
        logic              rej;
        logic [5:0][15:0]  exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vt[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, r0, q0, cnt;
        logic [20:0] e;
        logic [15:0] stall_exp [6];

        vt[0] = '{5'd5,  5'd1, 1'b0, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5}};
        vt[1] = '{5'd9,  5'd4, 1'b0, {16'd0, 16'd0, 16'd144, 16'd89, 16'd55, 16'd34}};
        vt[2] = '{5'd20, 5'd5, 1'b0, {16'd0, 16'd46368, 16'd28657, 16'd17711, 16'd10946, 16'd6765}};
        vt[3] = '{5'd20, 5'd6, 1'b1, '0};
        vt[4] = '{5'd0,  5'd0, 1'b1, '0};
        vt[5] = '{5'd24, 5'd1, 1'b0, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd46368}};
        vt[6] = '{5'd25, 5'd1, 1'b1, '0};
        vt[7] = '{5'd0,  5'd1, 1'b0, '0};
        stall_exp = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5};

        reset_n   = 1'b0;
        start     = 1'b0;
        first_s   = '0;
        count     = '0;
        res_ready = 1'b1;
        tick(3);

        check("rst_busy",        busy, 0);
        check("rst_cmd_err",     cmd_err, 0);
        check("rst_chk_err",     chk_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_res_valid",   res_valid, 0);
        check("rst_calc_reset",  calc_reset_n, 0);
        check("rst_begin",       begin_fibo, 0);
        check("rst_input_s",     input_s, 0);
        reset_n = 1'b1;
        check("calc_reset_still_low", calc_reset_n, 0);
        tick(1);
        check("calc_reset_rises", calc_reset_n, 1);
        tick(2);

        // Table-driven runs.
        for (int k = 0; k < NV; k++) begin
            b0 = begin_cnt;
            r0 = rstlow_cnt;
            q0 = got_q.size();
            cnt = int'(vt[k].cnt);
            run_cmd(vt[k].first, vt[k].cnt);
            if (vt[k].rej) begin
                check("rej_cmd_err_pulse", cmd_err, 1);
                check("rej_busy",          busy, 0);
                tick(1);
                check("rej_cmd_err_clear", cmd_err, 0);
                tick(12);
                check("rej_busy_later",    busy, 0);
                check("rej_no_begin",      begin_cnt - b0, 0);
            end else begin
                check("acc_busy",    busy, 1);
                check("acc_cmd_err", cmd_err, 0);
                wait_idle();
                tick(4);
                check("res_count", got_q.size() - q0, cnt);
                for (int i = 0; i < cnt && q0 + i < got_q.size(); i++) begin
                    e = got_q[q0 + i];
                    check("res_index", e[20:16], int'(vt[k].first) + i);
                    check("res_data",  e[15:0],  vt[k].exp[i]);
                end
                check("begin_cycles",   begin_cnt - b0, 2 * cnt);
                check("calc_rst_cycles", rstlow_cnt - r0, 2 * cnt);
                check("run_chk_err",    chk_err, 0);
                check("run_timeout",    timeout_err, 0);
                check("run_res_valid",  res_valid, 0);
            end
        end

        // FIFO back-pressure: 0..5 with ready low, stall in CAPTURE.
        res_ready = 1'b0;
        b0 = begin_cnt;
        q0 = got_q.size();
        run_cmd(5'd0, 5'd6);
        tick(150);
        check("stall_busy",      busy, 1);
        check("stall_res_valid", res_valid, 1);
        check("stall_head_idx",  res_index, 0);
        check("stall_head_data", res_data, 0);
        check("stall_begins",    begin_cnt - b0, 10);
        run_cmd(5'd0, 5'd0);
        check("busy_start_ignored", cmd_err, 0);
        tick(20);
        check("stall_holds", begin_cnt - b0, 10);
        res_ready = 1'b1;
        wait_idle();
        tick(4);
        check("stall_res_count", got_q.size() - q0, 6);
        for (int i = 0; i < 6 && q0 + i < got_q.size(); i++) begin
            e = got_q[q0 + i];
            check("stall_res_index", e[20:16], i);
            check("stall_res_data",  e[15:0],  stall_exp[i]);
        end

        // Recurrence checker: index 3 returns 7.
        bad3 = 1'b1;
        q0 = got_q.size();
        run_cmd(5'd1, 5'd4);
        for (int i = 0; i < 1000 && got_q.size() - q0 < 2; i++) tick(1);
        check("chk_clean_after_two", chk_err, 0);
        for (int i = 0; i < 1000 && got_q.size() - q0 < 3; i++) tick(1);
        check("chk_set_after_three", chk_err, 1);
        wait_idle();
        tick(4);
        check("chk_run_completes", got_q.size() - q0, 4);
        check("chk_sticky", chk_err, 1);
        bad3 = 1'b0;
        run_cmd(5'd2, 5'd2);
        check("chk_cleared_on_start", chk_err, 0);
        wait_idle();
        tick(4);

        // Timeout: calculator never completes.
        never_done = 1'b1;
        b0 = begin_cnt;
        r0 = rstlow_cnt;
        q0 = got_q.size();
        run_cmd(5'd3, 5'd2);
        wait_sig("to_begin_high", 1'b1, 0);
        wait_sig("to_begin_low",  1'b0, 0);
        cnt = 0;
        for (int i = 0; i < 200 && !timeout_err; i++) begin
            tick(1);
            cnt++;
        end
        check("to_wait_cycles", cnt, 64);
        check("to_flag",        timeout_err, 1);
        check("to_abort_rst",   calc_reset_n, 0);
        check("to_abort_busy",  busy, 1);
        tick(1);
        check("to_abort_rst2",  calc_reset_n, 0);
        tick(1);
        check("to_idle_busy",   busy, 0);
        check("to_idle_rst",    calc_reset_n, 1);
        check("to_rst_cycles",  rstlow_cnt - r0, 4);
        check("to_dropped",     begin_cnt - b0, 2);
        check("to_no_results",  got_q.size() - q0, 0);
        never_done = 1'b0;
        run_cmd(5'd4, 5'd1);
        check("to_cleared_on_start", timeout_err, 0);
        wait_idle();
        tick(4);

        // Reset during WAIT with FIFO occupied.
        res_ready = 1'b0;
        run_cmd(5'd7, 5'd3);
        wait_sig("mr_valid", 1'b1, 1);
        wait_sig("mr_begin_high", 1'b1, 0);
        wait_sig("mr_begin_low",  1'b0, 0);
        check("mr_pre_valid", res_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mr_busy",        busy, 0);
        check("mr_cmd_err",     cmd_err, 0);
        check("mr_chk_err",     chk_err, 0);
        check("mr_timeout_err", timeout_err, 0);
        check("mr_res_valid",   res_valid, 0);
        check("mr_calc_reset",  calc_reset_n, 0);
        check("mr_begin",       begin_fibo, 0);
        check("mr_input_s",     input_s, 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("mr_calc_reset_up", calc_reset_n, 1);
        check("mr_still_empty",   res_valid, 0);
        check("mr_idle",          busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
